instruction_fetch_unit: RTL and testbench

- Fetch-side initiator for `instruction_memory`.
- Holds the PC and issues word addresses to the memory, which has one cycle of read latency.
- Buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution, and halts on fetch faults (the memory reports invalid).

---
 rtl/riscv_pkg.sv | 17 +
 rtl/instruction_fetch_unit_fifo.sv | 65 ++++++
 rtl/instruction_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the fetch path: buffered fetch entry, fetch-unit state and reset PC.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    IFU_FETCH = 1'b0,
    IFU_FAULT = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with push/pop/flush, registered storage and an occupancy count.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output entry_t           head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: storage is reset too, so the head reads as zero out of reset; sequential state always uses <=.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, one-deep in-flight request tracking, fault FSM and decode-side buffer.
// Optional feature macro: IFU_PERF_COUNTERS_EN adds perf_fetched_o / perf_stall_o counters.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic                  imem_req_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  input  logic                  imem_valid_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  fault_o,
  output logic [ADDR_WIDTH-1:0] fault_pc_o
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_fetched_o,
  output logic [31:0]           perf_stall_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic                  fault_q;
  logic [ADDR_WIDTH-1:0] fault_pc_q;

  entry_t                push_entry;
  entry_t                head;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occupancy;
  logic                  pop;
  logic                  push;
  logic                  fault_evt;
  logic                  credit_ok;
  logic                  issue;

  // A redirect hides the head for one cycle so nothing is consumed from the stream being flushed.
  assign instr_valid_o = ~fifo_empty & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign push          = inflight_q & imem_valid_i & ~redirect_i;
  assign fault_evt     = inflight_q & ~imem_valid_i & ~redirect_i;

  // Count buffered plus in-flight entries so every response is guaranteed a free slot.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok = occupancy < ((CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop});

  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = imem_data_i;

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IFU_FETCH: begin
        issue = credit_ok & ~redirect_i;
        if (fault_evt) begin
          state_d = IFU_FAULT;
        end
      end
      IFU_FAULT: begin
        state_d = IFU_FAULT;
      end
      default: begin
        state_d = IFU_FETCH;
      end
    endcase
    if (redirect_i) begin
      state_d = IFU_FETCH;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IFU_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
    end else if (redirect_i) begin
      pc_q       <= redirect_pc_i;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + ADDR_WIDTH'(4);
        inflight_pc_q <= pc_q;
      end
      if (fault_evt) begin
        fault_q    <= 1'b1;
        fault_pc_q <= inflight_pc_q;
      end
    end
  end

  // Requests are masked while reset is asserted even though the FSM already sits in IFU_FETCH.
  assign imem_req_o  = issue & rst_ni;
  assign imem_addr_o = pc_q;
  assign fault_o     = fault_q;
  assign fault_pc_o  = fault_pc_q;
  assign instr_o     = head.instr;
  assign instr_pc_o  = head.pc;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if ((state_q == IFU_FETCH) && ~redirect_i && ~credit_ok) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed phases push expected {pc, instr}, a monitor checks handshakes.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic [31:0] imem_data_i;
  logic        imem_valid_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  instruction_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_addr_o   (imem_addr_o),
    .imem_req_o    (imem_req_o),
    .imem_data_i   (imem_data_i),
    .imem_valid_i  (imem_valid_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .fault_o       (fault_o),
    .fault_pc_o    (fault_pc_o)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .perf_fetched_o(perf_fetched_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  // Memory model: one cycle of latency, word-aligned addresses below 0x100 are valid.
  logic [31:0] mem_addr_q = 32'hFFFF_FFFF;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h009403b3;
      32'h04:  return 32'h40b503b3;
      32'h08:  return 32'h02d602b3;
      32'h10:  return 32'h013918b3;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (imem_req_o) mem_addr_q <= imem_addr_o;
  end

  assign imem_valid_i = (mem_addr_q < 32'h100) && (mem_addr_q[1:0] == 2'b00);
  assign imem_data_i  = imem_valid_i ? mem_word(mem_addr_q) : 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    sb_q.push_back('{pc: pc, instr: instr});
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},      imem_req_o,    1'b0);
    check({tag, "_addr"},     imem_addr_o,   32'h0);
    check({tag, "_valid"},    instr_valid_o, 1'b0);
    check({tag, "_instr"},    instr_o,       32'h0);
    check({tag, "_instr_pc"}, instr_pc_o,    32'h0);
    check({tag, "_fault"},    fault_o,       1'b0);
    check({tag, "_fault_pc"}, fault_pc_o,    32'h0);
  endtask

  // Asserts reset now, holds it over two edges and releases it just after a rising edge (start of C0).
  task automatic do_reset(input logic rdy);
    rst_ni        = 1'b0;
    instr_ready_i = rdy;
    redirect_i    = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni && instr_valid_o && instr_ready_i) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %0h instr %0h, required no handshake", instr_pc_o, instr_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc",    instr_pc_o, e.pc);
        check("sb_instr", instr_o,    e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b1;
    #3;
    check_reset_values("por");
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Phase 1: reset release, continuous ready.
    push_exp(32'h0, 32'h009403b3);
    push_exp(32'h4, 32'h40b503b3);
    push_exp(32'h8, 32'h02d602b3);
    @(negedge clk_i);
    check("c0_req",  imem_req_o,  1'b1);
    check("c0_addr", imem_addr_o, 32'h0);
    next_cycle();
    @(negedge clk_i);
    check("c1_valid", instr_valid_o, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      @(negedge clk_i);
      check("stream_valid", instr_valid_o, 1'b1);
    end
    next_cycle();
    instr_ready_i = 1'b0;
    check("p1_drained", sb_q.size(), 0);

    // Phase 2: backpressure C2..C6, release at C7.
    do_reset(1'b0);
    push_exp(32'h0, 32'h009403b3);
    push_exp(32'h4, 32'h40b503b3);
    push_exp(32'h8, 32'h02d602b3);
    push_exp(32'hC, 32'h0);
    next_cycle();
    for (int c = 2; c <= 6; c++) begin
      next_cycle();
      @(negedge clk_i);
      check("bp_valid",    instr_valid_o, 1'b1);
      check("bp_instr",    instr_o,       32'h009403b3);
      check("bp_instr_pc", instr_pc_o,    32'h0);
      if (c >= 3) check("bp_req_off", imem_req_o, 1'b0);
    end
    next_cycle();
    instr_ready_i = 1'b1;
    repeat (3) next_cycle();
    next_cycle();
    instr_ready_i = 1'b0;
    check("p2_drained", sb_q.size(), 0);

    // Phase 3: redirect to 0x10 in C5.
    do_reset(1'b1);
    push_exp(32'h0,  32'h009403b3);
    push_exp(32'h4,  32'h40b503b3);
    push_exp(32'h8,  32'h02d602b3);
    push_exp(32'h10, 32'h013918b3);
    repeat (4) next_cycle();
    next_cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h10;
    @(negedge clk_i);
    check("rd_c5_valid", instr_valid_o, 1'b0);
    check("rd_c5_req",   imem_req_o,    1'b0);
    next_cycle();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("rd_c6_valid", instr_valid_o, 1'b0);
    check("rd_c6_req",   imem_req_o,    1'b1);
    check("rd_c6_addr",  imem_addr_o,   32'h10);
    next_cycle();
    @(negedge clk_i);
    check("rd_c7_valid", instr_valid_o, 1'b0);
    next_cycle();
    @(negedge clk_i);
    check("rd_c8_valid", instr_valid_o, 1'b1);
    next_cycle();
    instr_ready_i = 1'b0;
    check("p3_drained", sb_q.size(), 0);

    // Phase 4: misaligned redirect faults; a redirect to 0 recovers.
    next_cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h1;
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    check("mis_r_valid", instr_valid_o, 1'b0);
    next_cycle();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("mis_req",  imem_req_o,  1'b1);
    check("mis_addr", imem_addr_o, 32'h1);
    next_cycle();
    @(negedge clk_i);
    check("mis_fault_early", fault_o, 1'b0);
    next_cycle();
    @(negedge clk_i);
    check("mis_fault",    fault_o,    1'b1);
    check("mis_fault_pc", fault_pc_o, 32'h1);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk_i);
      check("mis_halt_req",   imem_req_o,    1'b0);
      check("mis_halt_valid", instr_valid_o, 1'b0);
      check("mis_fault_hold", fault_o,       1'b1);
    end
    next_cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0;
    push_exp(32'h0, 32'h009403b3);
    next_cycle();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("rec_fault_clr", fault_o,     1'b0);
    check("rec_req",       imem_req_o,  1'b1);
    check("rec_addr",      imem_addr_o, 32'h0);
    next_cycle();
    @(negedge clk_i);
    check("rec_valid_early", instr_valid_o, 1'b0);
    next_cycle();
    @(negedge clk_i);
    check("rec_valid", instr_valid_o, 1'b1);
    next_cycle();
    instr_ready_i = 1'b0;
    check("p4_drained", sb_q.size(), 0);

    // Phase 5: redirect to 0xF8, buffered entries drain, then 0x100 faults.
    next_cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hF8;
    push_exp(32'hF8, 32'h0);
    push_exp(32'hFC, 32'h0);
    next_cycle();
    redirect_i = 1'b0;
    repeat (2) next_cycle();
    next_cycle();
    @(negedge clk_i);
    check("edge_full_req",   imem_req_o, 1'b0);
    check("edge_head_pc",    instr_pc_o, 32'hF8);
    check("edge_fault_none", fault_o,    1'b0);
    next_cycle();
    instr_ready_i = 1'b1;
    next_cycle();
    @(negedge clk_i);
    check("edge_fault_early", fault_o, 1'b0);
    next_cycle();
    @(negedge clk_i);
    check("edge_fault",    fault_o,       1'b1);
    check("edge_fault_pc", fault_pc_o,    32'h100);
    check("edge_valid",    instr_valid_o, 1'b0);
    check("p5_drained",    sb_q.size(),   0);
    next_cycle();
    @(negedge clk_i);
    check("edge_halt_req", imem_req_o, 1'b0);

    // Phase 6: async reset with a request in flight.
    next_cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0;
    next_cycle();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("ar_req", imem_req_o, 1'b1);
    next_cycle();
    #1;
    rst_ni = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk_i);
    check("async_hold_valid", instr_valid_o, 1'b0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    push_exp(32'h0, 32'h009403b3);
    push_exp(32'h4, 32'h40b503b3);
    @(negedge clk_i);
    check("ar_c0_req",  imem_req_o,  1'b1);
    check("ar_c0_addr", imem_addr_o, 32'h0);
    next_cycle();
    @(negedge clk_i);
    check("ar_c1_valid", instr_valid_o, 1'b0);
    next_cycle();
    @(negedge clk_i);
    check("ar_c2_valid", instr_valid_o, 1'b1);
    next_cycle();
    next_cycle();
    instr_ready_i = 1'b0;
    check("p6_drained", sb_q.size(), 0);

    repeat (2) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
